// File: rtl/dmem_arbiter_if.sv
// Bus bundle between the MEM stage, the DMA/debug requester, the data memory and dmem_arbiter.
// The arbiter takes the slave view; the surrounding pipeline, DMA engine and DataMem take the master view.
interface dmem_arbiter_if;
  logic       cpu_req;
  logic       cpu_we;
  logic [7:0] cpu_addr;
  logic [7:0] cpu_wdata;
  logic [7:0] cpu_rdata;
  logic       cpu_stall;

  logic       dma_valid;
  logic       dma_we;
  logic [7:0] dma_addr;
  logic [7:0] dma_wdata;
  logic       dma_ready;
  logic       dma_rvalid;
  logic [7:0] dma_rdata;
  logic       dma_rready;

  logic       mem_we;
  logic [7:0] mem_addr;
  logic [7:0] mem_wdata;
  logic [7:0] mem_rdata;

  modport slave (
    input  cpu_req, cpu_we, cpu_addr, cpu_wdata,
    output cpu_rdata, cpu_stall,
    input  dma_valid, dma_we, dma_addr, dma_wdata, dma_rready,
    output dma_ready, dma_rvalid, dma_rdata,
    output mem_we, mem_addr, mem_wdata,
    input  mem_rdata
  );

  modport master (
    output cpu_req, cpu_we, cpu_addr, cpu_wdata,
    input  cpu_rdata, cpu_stall,
    output dma_valid, dma_we, dma_addr, dma_wdata, dma_rready,
    input  dma_ready, dma_rvalid, dma_rdata,
    input  mem_we, mem_addr, mem_wdata,
    output mem_rdata
  );
endinterface

// File: rtl/dmem_arbiter.sv
// Data-memory arbiter: CPU MEM stage has priority, DMA gets a forced slot after MAX_WAIT denied cycles.
// Optional macro DMEM_ARB_STATS_EN adds a saturating 16-bit stall_count output.
module dmem_arbiter #(
  parameter int MAX_WAIT = 4,
  parameter int CNT_W    = 4
) (
  input  logic clk,
  input  logic reset,
  dmem_arbiter_if.slave bus
`ifdef DMEM_ARB_STATS_EN
  ,
  output logic [15:0] stall_count
`endif
);

  typedef enum logic {
    D_IDLE = 1'b0,
    D_RESP = 1'b1
  } dma_state_t;

  localparam logic [CNT_W-1:0] WAIT_LIMIT = CNT_W'(MAX_WAIT);

  dma_state_t       state_reg;
  logic [CNT_W-1:0] wait_cnt_reg;
  logic             dma_rvalid_reg;
  logic [7:0]       dma_rdata_reg;

  logic       dma_idle;
  logic       wait_expired;
  logic       dma_grant;
  logic       mem_we_sel;
  logic [7:0] mem_addr_sel;
  logic [7:0] mem_wdata_sel;

  assign dma_idle     = (state_reg == D_IDLE);
  assign wait_expired = (wait_cnt_reg == WAIT_LIMIT);
  assign dma_grant    = bus.dma_valid & dma_idle & (~bus.cpu_req | wait_expired);

  assign bus.dma_ready  = dma_grant;
  assign bus.cpu_stall  = bus.cpu_req & dma_grant;
  assign bus.cpu_rdata  = bus.mem_rdata;
  assign bus.dma_rvalid = dma_rvalid_reg;
  assign bus.dma_rdata  = dma_rdata_reg;

  // With no requester the CPU address still drives the memory so reads stay zero-latency.
  always_comb begin
    mem_we_sel    = bus.cpu_req & bus.cpu_we;
    mem_addr_sel  = bus.cpu_addr;
    mem_wdata_sel = bus.cpu_wdata;
    if (dma_grant) begin
      mem_we_sel    = bus.dma_we;
      mem_addr_sel  = bus.dma_addr;
      mem_wdata_sel = bus.dma_wdata;
    end
  end

  assign bus.mem_we    = mem_we_sel & ~reset;
  assign bus.mem_addr  = mem_addr_sel;
  assign bus.mem_wdata = mem_wdata_sel;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg      <= D_IDLE;
      wait_cnt_reg   <= '0;
      dma_rvalid_reg <= 1'b0;
      dma_rdata_reg  <= 8'h00;
    end else begin
      // Starvation counter only ages while the DMA is actually waiting for a slot.
      if (dma_grant || !bus.dma_valid) begin
        wait_cnt_reg <= '0;
      end else if (dma_idle && !wait_expired) begin
        wait_cnt_reg <= wait_cnt_reg + 1'b1;
      end

      case (state_reg)
        D_IDLE: begin
          if (dma_grant && !bus.dma_we) begin
            dma_rdata_reg  <= bus.mem_rdata;
            dma_rvalid_reg <= 1'b1;
            state_reg      <= D_RESP;
          end
        end
        D_RESP: begin
          if (bus.dma_rready) begin
            dma_rvalid_reg <= 1'b0;
            state_reg      <= D_IDLE;
          end
        end
        default: begin
          state_reg      <= D_IDLE;
          dma_rvalid_reg <= 1'b0;
        end
      endcase
    end
  end

`ifdef DMEM_ARB_STATS_EN
  logic [15:0] stall_count_reg;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stall_count_reg <= 16'h0000;
    end else if (bus.cpu_stall && (stall_count_reg != 16'hFFFF)) begin
      stall_count_reg <= stall_count_reg + 16'h0001;
    end
  end

  assign stall_count = stall_count_reg;
`endif

endmodule

// File: tb/tb_dmem_arbiter.sv
// Scoreboard bench for dmem_arbiter: a driver predicts per-cycle handshakes and read data from a
// transaction-level model; a negedge monitor pops and compares whatever the DUT presents.
module tb_dmem_arbiter;
  localparam int MAX_WAIT = 4;

  logic clk;
  logic reset;
  dmem_arbiter_if bus ();

`ifdef DMEM_ARB_STATS_EN
  logic [15:0] stall_count;
`endif

  dmem_arbiter #(.MAX_WAIT(MAX_WAIT), .CNT_W(4)) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
`ifdef DMEM_ARB_STATS_EN
    ,
    .stall_count(stall_count)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // DataMem: combinational read, write on the rising edge
  logic [7:0] env_mem [256];
  assign bus.mem_rdata = env_mem[bus.mem_addr];
  always @(posedge clk) if (bus.mem_we) env_mem[bus.mem_addr] <= bus.mem_wdata;

  // reference model state
  logic [7:0] ref_mem [256];
  bit         m_pend;
  int         m_denied;
  int         m_stalls;
  bit         m_last_grant;
  bit         m_last_stall;

  logic [3:0] q_ctl [$];   // {stall, ready, rvalid, mem_we}
  logic [7:0] q_cpu [$];
  logic [7:0] q_dma [$];

  int tests;
  int fails;

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic fail_now(input string name);
    tests++;
    fails++;
    $display("FAIL %s: DUT output with no expected entry at %0t", name, $time);
  endtask

  // One bus cycle: drive inputs, record what the model says this cycle must show, advance the model.
  task automatic drive(input logic creq, input logic cwe, input logic [7:0] caddr, input logic [7:0] cwd,
                       input logic dv, input logic dwe, input logic [7:0] daddr, input logic [7:0] dwd,
                       input logic rr);
    bit grant, stall, we;
    @(posedge clk);
    #1;
    bus.cpu_req = creq; bus.cpu_we = cwe; bus.cpu_addr = caddr; bus.cpu_wdata = cwd;
    bus.dma_valid = dv; bus.dma_we = dwe; bus.dma_addr = daddr; bus.dma_wdata = dwd;
    bus.dma_rready = rr;

    grant = dv && !m_pend && (!creq || m_denied >= MAX_WAIT);
    stall = creq && grant;
    we    = grant ? dwe : (creq && cwe);
    q_ctl.push_back({stall, grant, m_pend, we});
    if (creq && !cwe && !stall) q_cpu.push_back(ref_mem[caddr]);
    if (grant && !dwe) q_dma.push_back(ref_mem[daddr]);
    $display("[TB] cyc cpu(req=%0b we=%0b a=%02h) dma(v=%0b we=%0b a=%02h rr=%0b) exp stall=%0b ready=%0b rvalid=%0b",
             creq, cwe, caddr, dv, dwe, daddr, rr, stall, grant, m_pend);

    if (grant) begin
      if (dwe) ref_mem[daddr] = dwd;
    end else if (creq && cwe) begin
      ref_mem[caddr] = cwd;
    end
    if (grant || !dv) m_denied = 0;
    else if (!m_pend && m_denied < MAX_WAIT) m_denied++;
    if (grant && !dwe) m_pend = 1'b1;
    else if (m_pend && rr) m_pend = 1'b0;
    m_stalls     += int'(stall);
    m_last_grant = grant;
    m_last_stall = stall;
  endtask

  task automatic idle(input logic rr);
    drive(1'b0, 1'b0, 8'h00, 8'h00, 1'b0, 1'b0, 8'h00, 8'h00, rr);
  endtask

  // monitor
  always @(negedge clk) begin
    if (!reset) begin
      if (q_ctl.size() > 0) begin
        logic [3:0] e;
        e = q_ctl.pop_front();
        check("cpu_stall", 16'(bus.cpu_stall), 16'(e[3]));
        check("dma_ready", 16'(bus.dma_ready), 16'(e[2]));
        check("dma_rvalid", 16'(bus.dma_rvalid), 16'(e[1]));
        check("mem_we", 16'(bus.mem_we), 16'(e[0]));
      end
      if (bus.cpu_req && !bus.cpu_we && !bus.cpu_stall) begin
        if (q_cpu.size() == 0) fail_now("cpu_rdata");
        else check("cpu_rdata", 16'(bus.cpu_rdata), 16'(q_cpu.pop_front()));
      end
      if (bus.dma_rvalid) begin
        if (q_dma.size() == 0) fail_now("dma_rdata");
        else begin
          check("dma_rdata", 16'(bus.dma_rdata), 16'(q_dma[0]));
          if (bus.dma_rready) void'(q_dma.pop_front());
        end
      end
    end
  end

  initial begin
    #1ms;
    $display("FAIL watchdog: simulation did not finish, tests=%0d", tests);
    $fatal(1, "watchdog");
  end

  logic       r_creq, r_cwe, r_dv, r_dwe, r_rr;
  logic [7:0] r_caddr, r_cwd, r_daddr, r_dwd;
  bit         dma_done;

  initial begin
    tests = 0; fails = 0;
    m_pend = 0; m_denied = 0; m_stalls = 0; m_last_grant = 0; m_last_stall = 0;
    for (int i = 0; i < 256; i++) begin
      env_mem[i] = 8'(i * 37 + 11);
      ref_mem[i] = 8'(i * 37 + 11);
    end
    bus.cpu_req = 1'b1; bus.cpu_we = 1'b1; bus.cpu_addr = 8'h44; bus.cpu_wdata = 8'hEE;
    bus.dma_valid = 1'b0; bus.dma_we = 1'b0; bus.dma_addr = 8'h00; bus.dma_wdata = 8'h00;
    bus.dma_rready = 1'b0;
    reset = 1'b1;

    // reset state; a pending CPU store must not reach memory while reset is high
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_dma_rvalid", 16'(bus.dma_rvalid), 16'h0);
    check("rst_dma_rdata", 16'(bus.dma_rdata), 16'h0);
    check("rst_mem_we", 16'(bus.mem_we), 16'h0);
    check("rst_dma_ready", 16'(bus.dma_ready), 16'h0);
    bus.cpu_req = 1'b0; bus.cpu_we = 1'b0;
    reset = 1'b0;

    // CPU-only store then load
    drive(1'b1, 1'b1, 8'h10, 8'h5A, 1'b0, 1'b0, 8'h00, 8'h00, 1'b1);
    drive(1'b1, 1'b0, 8'h10, 8'h00, 1'b0, 1'b0, 8'h00, 8'h00, 1'b1);
    idle(1'b1);

    // DMA write, DMA read with backpressure and a second request waiting
    drive(1'b0, 1'b0, 8'h00, 8'h00, 1'b1, 1'b1, 8'h20, 8'hC3, 1'b1);
    drive(1'b0, 1'b0, 8'h00, 8'h00, 1'b1, 1'b0, 8'h20, 8'h00, 1'b0);
    repeat (3) drive(1'b0, 1'b0, 8'h00, 8'h00, 1'b1, 1'b0, 8'h10, 8'h00, 1'b0);
    drive(1'b0, 1'b0, 8'h00, 8'h00, 1'b1, 1'b0, 8'h10, 8'h00, 1'b1);
    drive(1'b0, 1'b0, 8'h00, 8'h00, 1'b1, 1'b0, 8'h10, 8'h00, 1'b0);
    idle(1'b0);

    // reset while a response is held
    @(negedge clk);
    #2;
    reset = 1'b1;
    bus.cpu_req = 1'b1; bus.cpu_we = 1'b1; bus.dma_valid = 1'b0;
    #1;
    check("midrst_dma_rvalid", 16'(bus.dma_rvalid), 16'h0);
    check("midrst_dma_rdata", 16'(bus.dma_rdata), 16'h0);
    check("midrst_mem_we", 16'(bus.mem_we), 16'h0);
    @(posedge clk);
    @(negedge clk);
    check("midrst_mem_we_hold", 16'(bus.mem_we), 16'h0);
    bus.cpu_req = 1'b0; bus.cpu_we = 1'b0;
    reset = 1'b0;
    m_pend = 0; m_denied = 0; m_stalls = 0;
    q_dma.delete();
    idle(1'b1);

    // contention, twice: DMA forced in on the fifth cycle
    for (int rep = 0; rep < 2; rep++) begin
      dma_done = 0;
      for (int k = 0; k < 7; k++) begin
        drive(1'b1, 1'b0, 8'h30, 8'h00, !dma_done, 1'b1, 8'h31, 8'(8'h77 + rep), 1'b1);
        dma_done = dma_done | m_last_grant;
      end
      idle(1'b1);
    end
`ifdef DMEM_ARB_STATS_EN
    @(negedge clk);
    check("stall_count_x2", stall_count, 16'd2);
`endif

    // randomized traffic
    r_dv = 1'b0; r_creq = 1'b0; r_cwe = 1'b0; r_caddr = 8'h00; r_cwd = 8'h00;
    r_dwe = 1'b0; r_daddr = 8'h00; r_dwd = 8'h00; r_rr = 1'b1;
    m_last_stall = 0;
    for (int n = 0; n < 1500; n++) begin
      if (!m_last_stall) begin
        r_creq  = ($urandom_range(0, 99) < 60);
        r_cwe   = 1'($urandom_range(0, 1));
        r_caddr = 8'($urandom_range(0, 15));
        r_cwd   = 8'($urandom);
      end
      if (!(r_dv && !m_last_grant)) begin
        r_dv    = ($urandom_range(0, 99) < 50);
        r_dwe   = 1'($urandom_range(0, 1));
        r_daddr = 8'($urandom_range(8, 23));
        r_dwd   = 8'($urandom);
      end
      r_rr = ($urandom_range(0, 99) < 60);
      drive(r_creq, r_cwe, r_caddr, r_cwd, r_dv, r_dwe, r_daddr, r_dwd, r_rr);
    end

    repeat (3) idle(1'b1);
    @(negedge clk);
    check("cpu_q_drain", 16'(q_cpu.size()), 16'h0);
    check("dma_q_drain", 16'(q_dma.size()), 16'h0);
    for (int a = 0; a < 32; a++) check("mem_final", 16'(env_mem[a]), 16'(ref_mem[a]));
`ifdef DMEM_ARB_STATS_EN
    check("stall_count_final", stall_count, 16'(m_stalls));
`endif
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
